// File: rtl/cache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module  : cache_axi_bridge
// Runs one cache-line read or write request as a single AXI4 INCR burst.
// Revision: 1.0
// ============================================================================
module cache_axi_bridge #(
   parameter int DATA_W    = 64,
   parameter int LINE_W    = 512,
   parameter int MAX_BEATS = 8
) (
   input  logic                clk,
   input  logic                rst,
   // cache-side request
   input  logic                i_cache_rw_axi_valid,
   input  logic                i_cache_rw_axi_op,
   input  logic [63:0]         i_cache_rw_axi_addr,
   input  logic [LINE_W-1:0]   i_cache_rw_axi_wdata,
   input  logic [1:0]          i_cache_rw_axi_size,
   input  logic [7:0]          i_cache_rw_axi_blks,
   output logic                o_cache_rw_axi_ready,
   output logic [LINE_W-1:0]   o_cache_rw_axi_rdata,
   output logic                o_cache_rw_axi_err,
   // AW channel
   output logic                o_axi_aw_valid,
   output logic [63:0]         o_axi_aw_addr,
   output logic [7:0]          o_axi_aw_len,
   output logic [2:0]          o_axi_aw_size,
   input  logic                i_axi_aw_ready,
   // W channel
   output logic                o_axi_w_valid,
   output logic [DATA_W-1:0]   o_axi_w_data,
   output logic [7:0]          o_axi_w_strb,
   output logic                o_axi_w_last,
   input  logic                i_axi_w_ready,
   // B channel
   input  logic                i_axi_b_valid,
   input  logic [1:0]          i_axi_b_resp,
   output logic                o_axi_b_ready,
   // AR channel
   output logic                o_axi_ar_valid,
   output logic [63:0]         o_axi_ar_addr,
   output logic [7:0]          o_axi_ar_len,
   output logic [2:0]          o_axi_ar_size,
   input  logic                i_axi_ar_ready,
   // R channel
   input  logic                i_axi_r_valid,
   input  logic [DATA_W-1:0]   i_axi_r_data,
   input  logic [1:0]          i_axi_r_resp,
   input  logic                i_axi_r_last,
   output logic                o_axi_r_ready
);

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_AR   = 3'd1;
   localparam logic [2:0] c_R    = 3'd2;
   localparam logic [2:0] c_AW   = 3'd3;
   localparam logic [2:0] c_W    = 3'd4;
   localparam logic [2:0] c_B    = 3'd5;
   localparam logic [2:0] c_DONE = 3'd6;

   // Beat counter saturates here so a runaway R burst cannot wrap back into range.
   localparam logic [3:0] c_BEAT_SAT = 4'(MAX_BEATS);

   logic [2:0]          state_q,    state_d;
   logic [3:0]          beat_cnt_q, beat_cnt_d;
   logic [2:0]          len_q,      len_d;
   logic [LINE_W-1:0]   wdata_q,    wdata_d;
   logic [LINE_W-1:0]   rdata_q,    rdata_d;
   logic                err_q,      err_d;
   logic                ready_q,    ready_d;

   logic                aw_valid_q, aw_valid_d;
   logic [63:0]         aw_addr_q,  aw_addr_d;
   logic [7:0]          aw_len_q,   aw_len_d;
   logic [2:0]          aw_size_q,  aw_size_d;

   logic                w_valid_q,  w_valid_d;
   logic [DATA_W-1:0]   w_data_q,   w_data_d;
   logic [7:0]          w_strb_q,   w_strb_d;
   logic                w_last_q,   w_last_d;
   logic                b_ready_q,  b_ready_d;

   logic                ar_valid_q, ar_valid_d;
   logic [63:0]         ar_addr_q,  ar_addr_d;
   logic [7:0]          ar_len_q,   ar_len_d;
   logic [2:0]          ar_size_q,  ar_size_d;
   logic                r_ready_q,  r_ready_d;

   logic [3:0]          w_beat_nxt;
   logic [8:0]          w_rd_base;
   logic [8:0]          w_wr_base;
   logic                unused_blks_hi;

   assign w_beat_nxt     = beat_cnt_q + 4'd1;
   assign w_rd_base      = {beat_cnt_q[2:0], 6'd0};
   assign w_wr_base      = {w_beat_nxt[2:0], 6'd0};
   assign unused_blks_hi = ^i_cache_rw_axi_blks[7:3];

   function automatic logic [7:0] strb_for(input logic [1:0] size, input logic [2:0] off);
      logic [7:0] lanes;
      case (size)
         2'd0:    lanes = 8'h01;
         2'd1:    lanes = 8'h03;
         2'd2:    lanes = 8'h0F;
         default: lanes = 8'hFF;
      endcase
      return (size == 2'd3) ? 8'hFF : (lanes << off);
   endfunction

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      len_d      = len_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      ready_d    = 1'b0;
      aw_valid_d = aw_valid_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      w_valid_d  = w_valid_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      w_last_d   = w_last_q;
      b_ready_d  = b_ready_q;
      ar_valid_d = ar_valid_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      r_ready_d  = r_ready_q;

      case (state_q)
         c_IDLE: begin
            if (i_cache_rw_axi_valid) begin
               len_d      = i_cache_rw_axi_blks[2:0];
               wdata_d    = i_cache_rw_axi_wdata;
               beat_cnt_d = 4'd0;
               err_d      = 1'b0;
               if (!i_cache_rw_axi_op) begin
                  state_d    = c_AR;
                  rdata_d    = '0;
                  ar_valid_d = 1'b1;
                  ar_addr_d  = i_cache_rw_axi_addr;
                  ar_len_d   = {5'b0, i_cache_rw_axi_blks[2:0]};
                  ar_size_d  = {1'b0, i_cache_rw_axi_size};
               end else begin
                  state_d    = c_AW;
                  aw_valid_d = 1'b1;
                  aw_addr_d  = i_cache_rw_axi_addr;
                  aw_len_d   = {5'b0, i_cache_rw_axi_blks[2:0]};
                  aw_size_d  = {1'b0, i_cache_rw_axi_size};
                  w_strb_d   = strb_for(i_cache_rw_axi_size, i_cache_rw_axi_addr[2:0]);
               end
            end
         end

         c_AR: begin
            if (i_axi_ar_ready) begin
               ar_valid_d = 1'b0;
               r_ready_d  = 1'b1;
               state_d    = c_R;
            end
         end

         c_R: begin
            if (i_axi_r_valid && r_ready_q) begin
               // Beats past the requested length are dropped but still flag an error.
               if (beat_cnt_q <= {1'b0, len_q}) begin
                  rdata_d[w_rd_base +: DATA_W] = i_axi_r_data;
               end else begin
                  err_d = 1'b1;
               end
               if (i_axi_r_resp != 2'b00) begin
                  err_d = 1'b1;
               end
               if (beat_cnt_q != c_BEAT_SAT) begin
                  beat_cnt_d = w_beat_nxt;
               end
               if (i_axi_r_last) begin
                  r_ready_d = 1'b0;
                  ready_d   = 1'b1;
                  state_d   = c_DONE;
               end
            end
         end

         c_AW: begin
            if (i_axi_aw_ready) begin
               aw_valid_d = 1'b0;
               w_valid_d  = 1'b1;
               w_data_d   = wdata_q[DATA_W-1:0];
               w_last_d   = (len_q == 3'd0);
               state_d    = c_W;
            end
         end

         c_W: begin
            if (i_axi_w_ready) begin
               if (w_last_q) begin
                  w_valid_d = 1'b0;
                  w_last_d  = 1'b0;
                  b_ready_d = 1'b1;
                  state_d   = c_B;
               end else begin
                  beat_cnt_d = w_beat_nxt;
                  w_data_d   = wdata_q[w_wr_base +: DATA_W];
                  w_last_d   = (w_beat_nxt[2:0] == len_q);
               end
            end
         end

         c_B: begin
            if (i_axi_b_valid) begin
               b_ready_d = 1'b0;
               ready_d   = 1'b1;
               if (i_axi_b_resp != 2'b00) begin
                  err_d = 1'b1;
               end
               state_d = c_DONE;
            end
         end

         c_DONE: begin
            state_d = c_IDLE;
         end

         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= c_IDLE;
         beat_cnt_q <= '0;
         len_q      <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         ready_q    <= 1'b0;
         aw_valid_q <= 1'b0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         w_valid_q  <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         w_last_q   <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         r_ready_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         ready_q    <= ready_d;
         aw_valid_q <= aw_valid_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         w_valid_q  <= w_valid_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         w_last_q   <= w_last_d;
         b_ready_q  <= b_ready_d;
         ar_valid_q <= ar_valid_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         r_ready_q  <= r_ready_d;
      end
   end

   assign o_cache_rw_axi_ready = ready_q;
   assign o_cache_rw_axi_rdata = rdata_q;
   assign o_cache_rw_axi_err   = err_q;
   assign o_axi_aw_valid       = aw_valid_q;
   assign o_axi_aw_addr        = aw_addr_q;
   assign o_axi_aw_len         = aw_len_q;
   assign o_axi_aw_size        = aw_size_q;
   assign o_axi_w_valid        = w_valid_q;
   assign o_axi_w_data         = w_data_q;
   assign o_axi_w_strb         = w_strb_q;
   assign o_axi_w_last         = w_last_q;
   assign o_axi_b_ready        = b_ready_q;
   assign o_axi_ar_valid       = ar_valid_q;
   assign o_axi_ar_addr        = ar_addr_q;
   assign o_axi_ar_len         = ar_len_q;
   assign o_axi_ar_size        = ar_size_q;
   assign o_axi_r_ready        = r_ready_q;

endmodule
`default_nettype wire
